// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2
  } state_e;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned TIMEOUT_DEF = 4096;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set req bit starting at last_grant+1.
module rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         last_grant,
  output logic [2:0]         winner,
  output logic               valid
);

  int unsigned lg;
  int unsigned idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    lg     = {29'd0, last_grant};
    idx    = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (lg + i) % NUM_REQ;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = 3'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters,
// with per-frame completion ack and BUSY timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ     = NUM_REQ_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic                 tx_tick,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 err,
  output logic                 tx_start,
  output logic [7:0]           tx_din,
  input  logic                 tx_done,
  output logic [2:0]           grant_id,
  output logic                 busy
);

  localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0]      CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [NUM_REQ-1:0] ACK_ONE  = NUM_REQ'(1);

  state_e               state_q, state_d;
  logic [2:0]           grant_q, grant_d;
  logic [2:0]           last_q, last_d;
  logic [7:0]           din_q, din_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 done_q;
  logic                 done_rise;
  logic [2:0]           pick_winner;
  logic                 pick_valid;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req        (req),
    .last_grant (last_q),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  // done_q tracks tx_done every cycle, so a level already high on BUSY entry is not an edge.
  assign done_rise = tx_done & ~done_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    din_d   = din_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = LAUNCH;
          grant_d = pick_winner;
          din_d   = req_data[8*pick_winner +: 8];
        end
      end
      LAUNCH: begin
        state_d = BUSY;
        cnt_d   = '0;
      end
      BUSY: begin
        // Completion is tested first so it beats a coincident timeout.
        if (done_rise) begin
          ack_d   = ACK_ONE << grant_q;
          last_d  = grant_q;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          last_d  = grant_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge tx_tick) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 3'(NUM_REQ - 1);
      din_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      done_q  <= tx_done;
    end
  end

  assign tx_start = (state_q == LAUNCH);
  assign busy     = (state_q != IDLE);
  assign ack      = ack_q;
  assign err      = err_q;
  assign tx_din   = din_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (default timeout and a 16-cycle timeout instance).
module tb_uart_tx_arbiter;

  logic        tx_tick = 1'b0;
  logic        reset;
  logic [3:0]  req, to_req;
  logic [31:0] req_data, to_req_data;
  logic [3:0]  ack, to_ack;
  logic        err, to_err;
  logic        tx_start, to_start;
  logic [7:0]  tx_din, to_din;
  logic        tx_done, to_done;
  logic [2:0]  grant_id, to_grant;
  logic        busy, to_busy;

  int checks = 0;
  int errors = 0;

  always #5 tx_tick = ~tx_tick;

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(4096)) dut (
    .tx_tick (tx_tick), .reset (reset), .req (req), .req_data (req_data),
    .ack (ack), .err (err), .tx_start (tx_start), .tx_din (tx_din),
    .tx_done (tx_done), .grant_id (grant_id), .busy (busy)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(16)) u_to (
    .tx_tick (tx_tick), .reset (reset), .req (to_req), .req_data (to_req_data),
    .ack (to_ack), .err (to_err), .tx_start (to_start), .tx_din (to_din),
    .tx_done (to_done), .grant_id (to_grant), .busy (to_busy)
  );

  task automatic tick();
    @(posedge tx_tick);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; to_req = '0; tx_done = 1'b0; to_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; to_req = '0; tx_done = 1'b0; to_done = 1'b0;
    req_data = '0; to_req_data = '0;
    tick(); tick();
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b exp 0", tx_start); end
    checks++; if (tx_din !== 8'h00) begin errors++; $display("FAIL reset_tx_din: got %h exp 00", tx_din); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b exp 0000", ack); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_grant: got %0d exp 0", grant_id); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    req_data = 32'h0000_00A5; req = 4'b0001;
    tick();
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL basic_start: got %b exp 1", tx_start); end
    checks++; if (tx_din !== 8'hA5) begin errors++; $display("FAIL basic_din: got %h exp a5", tx_din); end
    checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL basic_grant: got %0d exp 0", grant_id); end
    req = '0;
    tick();
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL basic_start_once: got %b exp 0", tx_start); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b exp 1", busy); end
    repeat (19) tick();
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL basic_early_ack: got %b exp 0000", ack); end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL basic_ack: got %b exp 0001", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b exp 0", busy); end
    tick();
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL basic_ack_pulse: got %b exp 0000", ack); end
  endtask

  task automatic test_round_robin();
    int   exp_order [5] = '{0, 1, 2, 3, 0};
    bit   got;
    logic [7:0] eb;
    do_reset();
    req_data = 32'h4433_2211; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        tick();
        if (tx_start === 1'b1) got = 1'b1;
      end
      checks++; if (!got) begin errors++; $display("FAIL rr_start_%0d: got no tx_start exp pulse within 8 cycles", k); end
      eb = 8'(8'h11 * (exp_order[k] + 1));
      checks++; if (grant_id !== 3'(exp_order[k])) begin errors++; $display("FAIL rr_grant_%0d: got %0d exp %0d", k, grant_id, exp_order[k]); end
      checks++; if (tx_din !== eb) begin errors++; $display("FAIL rr_din_%0d: got %h exp %h", k, tx_din, eb); end
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rr_ack_clear_%0d: got %b exp 0000", k, ack); end
      tick(); tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      checks++; if (ack !== (4'b0001 << exp_order[k])) begin errors++; $display("FAIL rr_ack_%0d: got %b exp %b", k, ack, 4'b0001 << exp_order[k]); end
    end
    req = '0;
  endtask

  task automatic test_done_level();
    int acks;
    do_reset();
    req_data = 32'h0000_005A; req = 4'b0001;
    tick();
    req = '0; tx_done = 1'b1; acks = 0;
    repeat (4) begin tick(); if (ack !== 4'b0000) acks++; end
    tx_done = 1'b0;
    repeat (3) begin tick(); if (ack !== 4'b0000) acks++; end
    checks++; if (acks !== 0) begin errors++; $display("FAIL level_no_ack: got %0d acks exp 0", acks); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL level_busy: got %b exp 1", busy); end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL level_ack: got %b exp 0001", ack); end
    tick();
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL level_ack_once: got %b exp 0000", ack); end
  endtask

  task automatic test_timeout();
    int n;
    int acks;
    do_reset();
    to_req_data = 32'h4433_2211; to_req = 4'b0011;
    tick();
    checks++; if (to_grant !== 3'd0) begin errors++; $display("FAIL to_first_grant: got %0d exp 0", to_grant); end
    tick();
    n = 0; acks = 0;
    for (int c = 0; c < 40; c++) begin
      tick(); n++;
      if (to_ack !== 4'b0000) acks++;
      if (to_err === 1'b1) break;
    end
    checks++; if (to_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b exp 1 within 40 cycles", to_err); end
    checks++; if (n !== 16) begin errors++; $display("FAIL to_latency: got %0d exp 16", n); end
    checks++; if (acks !== 0) begin errors++; $display("FAIL to_no_ack: got %0d acks exp 0", acks); end
    tick();
    checks++; if (to_err !== 1'b0) begin errors++; $display("FAIL to_err_pulse: got %b exp 0", to_err); end
    checks++; if (to_start !== 1'b1) begin errors++; $display("FAIL to_next_start: got %b exp 1", to_start); end
    checks++; if (to_grant !== 3'd1) begin errors++; $display("FAIL to_next_grant: got %0d exp 1", to_grant); end
    checks++; if (to_din !== 8'h22) begin errors++; $display("FAIL to_next_din: got %h exp 22", to_din); end
    to_req = '0;
  endtask

  task automatic test_tie();
    do_reset();
    to_req_data = 32'h0000_0011; to_req = 4'b0001;
    tick();
    to_req = '0;
    tick();
    repeat (15) tick();
    to_done = 1'b1;
    tick();
    to_done = 1'b0;
    checks++; if (to_ack !== 4'b0001) begin errors++; $display("FAIL tie_ack: got %b exp 0001", to_ack); end
    checks++; if (to_err !== 1'b0) begin errors++; $display("FAIL tie_err: got %b exp 0", to_err); end
    checks++; if (to_busy !== 1'b0) begin errors++; $display("FAIL tie_idle: got %b exp 0", to_busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_data = 32'h0000_00C3; req = 4'b0001;
    tick(); tick(); tick();
    req = '0; reset = 1'b1; tx_done = 1'b1;
    tick();
    checks++; if ({tx_start, tx_din, ack, err, busy, grant_id} !== 17'd0)
      begin errors++; $display("FAIL midreset_outputs: got start=%b din=%h ack=%b err=%b busy=%b grant=%0d exp all 0", tx_start, tx_din, ack, err, busy, grant_id); end
    reset = 1'b0; tx_done = 1'b0;
    req = 4'b1000; req_data = 32'h7E00_0000;
    tick();
    checks++; if (grant_id !== 3'd3) begin errors++; $display("FAIL midreset_grant: got %0d exp 3", grant_id); end
    checks++; if (tx_din !== 8'h7E) begin errors++; $display("FAIL midreset_din: got %h exp 7e", tx_din); end
    req = '0;
  endtask

  task automatic test_drop();
    do_reset();
    req_data = 32'h00D2_0000; req = 4'b0100;
    tick();
    checks++; if (grant_id !== 3'd2) begin errors++; $display("FAIL drop_grant: got %0d exp 2", grant_id); end
    tick();
    req = '0;
    repeat (3) tick();
    checks++; if (tx_din !== 8'hD2) begin errors++; $display("FAIL drop_din_hold: got %h exp d2", tx_din); end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL drop_ack: got %b exp 0100", ack); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle: got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_data = 32'h0000_BBAA; req = 4'b0011;
    tick();
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL b2b_ack: got %b exp 0001", ack); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL b2b_idle_start: got %b exp 0", tx_start); end
    tick();
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL b2b_start: got %b exp 1", tx_start); end
    checks++; if (grant_id !== 3'd1) begin errors++; $display("FAIL b2b_grant: got %0d exp 1", grant_id); end
    checks++; if (tx_din !== 8'hBB) begin errors++; $display("FAIL b2b_din: got %h exp bb", tx_din); end
    req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion exp finish before 200000 time units");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_done_level();
    test_timeout();
    test_tie();
    test_reset_mid();
    test_drop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing one Transmitter; legal range is 2..8.
REQ-002 Parameter TIMEOUT_CYC, default 4096, SHALL set the maximum BUSY cycles allowed before the frame is abandoned.
REQ-003 Port tx_tick, input, 1, SHALL be the single clock; it is the same tick that clocks the Transmitter.
REQ-004 Port reset, input, 1, SHALL be a synchronous, active-high reset.
REQ-005 Port req, input, NUM_REQ, SHALL carry per-requester transmit requests, level-sensitive.
REQ-006 Port req_data, input, NUM_REQ*8, SHALL carry the byte for requester i on bits [8i+7:8i].
REQ-007 Port ack, output, NUM_REQ, SHALL carry a one-cycle completion pulse to the granted requester.
REQ-008 Port err, output, 1, SHALL carry a one-cycle timeout pulse.
REQ-009 Port tx_start, output, 1, SHALL drive the Transmitter start input.
REQ-010 Port tx_din, output, 8, SHALL drive the Transmitter data input.
REQ-011 Port tx_done, input, 1, SHALL be the Transmitter done level.
REQ-012 Port grant_id, output, 3, SHALL hold the index of the current or last granted requester.
REQ-013 Port busy, output, 1, SHALL be high in every state except IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, LAUNCH and BUSY; any other encoding SHALL go to IDLE.
REQ-015 In IDLE with req != 0, the arbiter SHALL pick the first set req bit searching round-robin from last_grant+1, modulo NUM_REQ, and move to LAUNCH on the next edge.
REQ-016 On that same edge, tx_din SHALL latch req_data[winner] and grant_id SHALL latch the winner index.
REQ-017 In LAUNCH, tx_start SHALL be 1 for exactly one cycle, and the next state SHALL be BUSY.
REQ-018 tx_start SHALL be 0 in IDLE and BUSY.
REQ-019 tx_din SHALL stay constant from LAUNCH until return to IDLE.
REQ-020 Completion SHALL be the 0->1 edge of tx_done, detected with a registered copy of tx_done. A level that is already high on entry to BUSY SHALL NOT count.
REQ-021 On completion:
- ack[grant_id] SHALL be 1 for one cycle;
- last_grant SHALL become grant_id;
- the state SHALL return to IDLE.
REQ-022 A BUSY cycle counter SHALL clear on entry to BUSY. When it reaches TIMEOUT_CYC-1 without completion:
- err SHALL pulse for one cycle;
- no ack SHALL be issued;
- last_grant SHALL still advance;
- the state SHALL return to IDLE.
REQ-023 If completion and timeout occur in the same cycle, completion SHALL win: ack pulses and err stays 0.
REQ-024 A requester that drops req after the grant SHALL still see its frame completed and its ack pulsed.
REQ-025 A requester holding req after ack SHALL be re-eligible, but SHALL NOT be granted again while another req bit is set.
REQ-026 req changes during LAUNCH and BUSY SHALL have no effect until the next IDLE cycle.
REQ-027 The minimum spacing between consecutive tx_start pulses SHALL be completion + 2 cycles (IDLE, then LAUNCH).
REQ-028 ack SHALL be one-hot or zero at all times; ack and err SHALL never be 1 together.

Reset
REQ-029 While reset is 1 at a tx_tick edge, the following SHALL hold:
- state = IDLE;
- tx_start = 0, tx_din = 0, ack = 0, err = 0, busy = 0;
- grant_id = 0;
- last_grant = NUM_REQ-1, so requester 0 has first priority;
- the timeout counter and the registered tx_done SHALL be 0.
REQ-030 Reset asserted during LAUNCH or BUSY SHALL abandon the frame with no ack and no err.

Structure
REQ-031 A shared package uart_pkg SHALL hold the FSM state typedef (IDLE, LAUNCH, BUSY) and the default constants NUM_REQ_DEF and TIMEOUT_DEF.
REQ-032 The round-robin winner search SHALL be one combinational sub-module, rr_pick, with inputs req and last_grant and outputs winner and valid.
REQ-033 The top level SHALL instantiate no Transmitter; the Transmitter connects at the parent level.

Verification
REQ-034 After reset, req=4'b0001 with data 8'hA5 -> one tx_start pulse, tx_din=8'hA5 and grant_id=0; a tx_done edge 20 cycles later -> ack=4'b0001 for one cycle, then busy=0.
REQ-035 req=4'b1111 held, every frame completed -> grant order 0,1,2,3,0 with exactly one ack per frame.
REQ-036 tx_done held high at entry to BUSY, then low, then high -> exactly one ack, on the second rising edge only.
REQ-037 TIMEOUT_CYC=16, tx_done never rising -> err pulses 16 cycles after entering BUSY, with no ack; the next requester is then granted.
REQ-038 reset=1 in mid-BUSY -> all outputs 0 on the next edge; after release with req=4'b1000 -> grant_id=3.
REQ-039 req[2] dropped one cycle after its grant -> the frame still completes and ack[2] pulses.
